// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the 1-to-N stream demultiplexer.
// Kept separate so channel-count math is identical everywhere.
package stream_demux_pkg;

    localparam int DEFAULT_N = 8;
    localparam int DEFAULT_W = 8;

    function automatic int sel_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry registered output slot with valid/ready drain.
// A load on a draining edge wins, so the slot refills without a bubble.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         free
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    assign free      = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/stream_demux.sv
// Parametrised 1-to-N stream demux with broadcast and a saturating
// counter for words addressed past the last channel.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int W  = DEFAULT_W,
    parameter int CW = 8,
    localparam int SELW = sel_width(N)
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [W-1:0]    IN_DATA,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [SELW-1:0] SEL,
    input  logic            BCAST,
    output logic [N*W-1:0]  OUT_DATA,
    output logic [N-1:0]    OUT_VALID,
    input  logic [N-1:0]    OUT_READY,
    output logic [CW-1:0]   DROP_CNT
);

    logic [N-1:0]  free;
    logic [N-1:0]  load;
    logic [31:0]   sel_ext;
    logic          in_range;
    logic          sel_free;
    logic          accept;
    logic          drop;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    // Widened so the range test stays meaningful when N is a power of two.
    assign sel_ext  = 32'(SEL);
    assign in_range = sel_ext < 32'(N);

    always_comb begin
        sel_free = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel_ext == 32'(i)) sel_free = free[i];
        end
    end

    always_comb begin
        if (BCAST)         IN_READY = &free;
        else if (in_range) IN_READY = sel_free;
        else               IN_READY = 1'b1;
    end

    assign accept = IN_VALID && IN_READY;
    assign drop   = accept && !BCAST && !in_range;

    always_comb begin
        load = '0;
        for (int i = 0; i < N; i++) begin
            load[i] = accept && (BCAST || sel_ext == 32'(i));
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_slot
        demux_slot #(.W(W)) u_slot (
            .CLK       (CLK),
            .nRST      (nRST),
            .load      (load[g]),
            .load_data (IN_DATA),
            .out_ready (OUT_READY[g]),
            .out_valid (OUT_VALID[g]),
            .out_data  (OUT_DATA[g*W +: W]),
            .free      (free[g])
        );
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CW'(1);
    end

    assign DROP_CNT = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboarded random and directed bench for stream_demux (N=8) plus a
// small N=6/CW=2 instance for the out-of-range drop path.
module tb_stream_demux;

    localparam int N = 8;

    logic          CLK = 1'b0;
    logic          nRST;
    logic [7:0]    IN_DATA;
    logic          IN_VALID;
    logic          IN_READY;
    logic [2:0]    SEL;
    logic          BCAST;
    logic [63:0]   OUT_DATA;
    logic [7:0]    OUT_VALID;
    logic [7:0]    OUT_READY;
    logic [7:0]    DROP_CNT;

    logic [7:0]    d6;
    logic          v6, r6;
    logic [2:0]    s6;
    logic          b6;
    logic [47:0]   od6;
    logic [5:0]    ov6, or6;
    logic [1:0]    dc6;

    int errs = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    logic [7:0] q[N][$];

    always #5 CLK = ~CLK;

    stream_demux #(.N(8), .W(8), .CW(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .SEL(SEL), .BCAST(BCAST),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .DROP_CNT(DROP_CNT)
    );

    stream_demux #(.N(6), .W(8), .CW(2)) dut6 (
        .CLK(CLK), .nRST(nRST),
        .IN_DATA(d6), .IN_VALID(v6), .IN_READY(r6),
        .SEL(s6), .BCAST(b6),
        .OUT_DATA(od6), .OUT_VALID(ov6), .OUT_READY(or6),
        .DROP_CNT(dc6)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: each channel is a FIFO of undelivered words, depth <= 1.
    function automatic bit model_ready(input int sel, input bit bc);
        bit r = 1'b1;
        if (bc) begin
            for (int c = 0; c < N; c++)
                if (q[c].size() != 0 && !OUT_READY[c]) r = 1'b0;
        end else if (sel < N) begin
            r = (q[sel].size() == 0) || OUT_READY[sel];
        end
        return r;
    endfunction

    always @(negedge CLK) begin
        if (mon_en && nRST) begin
            for (int c = 0; c < N; c++) begin
                chk($sformatf("out_valid[%0d]", c), 64'(OUT_VALID[c]),
                    64'(q[c].size() != 0));
                if (OUT_VALID[c] && q[c].size() != 0) begin
                    chk($sformatf("out_data[%0d]", c),
                        64'(OUT_DATA[c*8 +: 8]), 64'(q[c][0]));
                    if (OUT_READY[c]) void'(q[c].pop_front());
                end
            end
        end
    end

    task automatic send(input int sel, input bit bc, input logic [7:0] d,
                        input bit rnd, output int waits);
        bit ok = 1'b0;
        waits = 0;
        SEL = 3'(sel);
        BCAST = bc;
        IN_DATA = d;
        IN_VALID = 1'b1;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge CLK);
            #1;
            chk("in_ready", 64'(IN_READY), 64'(model_ready(sel, bc)));
            if (IN_READY) begin
                ok = 1'b1;
                if (bc) begin
                    for (int c = 0; c < N; c++) q[c].push_back(d);
                end else if (sel < N) begin
                    q[sel].push_back(d);
                end
            end else begin
                waits++;
            end
            @(posedge CLK);
            #1;
            if (!ok && rnd) OUT_READY = 8'($urandom);
        end
        IN_VALID = 1'b0;
        if (!ok) chk("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        int w;
        nRST = 1'b1;
        IN_DATA = '0; IN_VALID = 1'b0; SEL = '0; BCAST = 1'b0;
        OUT_READY = 8'hFF;
        d6 = '0; v6 = 1'b0; s6 = '0; b6 = 1'b0; or6 = '1;
        #2 nRST = 1'b0;
        #1;
        chk("rst_valid", 64'(OUT_VALID), 64'(0));
        chk("rst_drop", 64'(DROP_CNT), 64'(0));
        chk("rst_valid6", 64'(ov6), 64'(0));
        chk("rst_drop6", 64'(dc6), 64'(0));
        @(negedge CLK);
        #2 nRST = 1'b1;
        mon_en = 1'b1;
        idle(1);

        for (int s = 0; s < 8; s++) begin
            send(s, 1'b0, 8'(8'hA0 + s), 1'b0, w);
            chk("sweep_valid", 64'(OUT_VALID), 64'(1) << s);
            chk("sweep_data", 64'(OUT_DATA[s*8 +: 8]), 64'(8'hA0 + s));
            chk("sweep_wait", 64'(w), 64'(0));
        end
        idle(2);

        OUT_READY = 8'hF7;
        send(3, 1'b0, 8'h11, 1'b0, w);
        chk("bp_first_wait", 64'(w), 64'(0));
        send(5, 1'b0, 8'h55, 1'b0, w);
        chk("bp_other_ch_wait", 64'(w), 64'(0));
        fork
            send(3, 1'b0, 8'h22, 1'b0, w);
            begin
                repeat (2) @(posedge CLK);
                #2 OUT_READY = 8'hFF;
            end
        join
        chk("bp_stall_wait", 64'(w), 64'(2));
        chk("bp_valid3", 64'(OUT_VALID[3]), 64'(1));
        chk("bp_data3", 64'(OUT_DATA[24 +: 8]), 64'(8'h22));
        idle(2);

        OUT_READY = 8'hFE;
        send(0, 1'b1, 8'h5A, 1'b0, w);
        chk("bc_wait", 64'(w), 64'(0));
        chk("bc_valid", 64'(OUT_VALID), 64'(8'hFF));
        chk("bc_data", OUT_DATA, {8{8'h5A}});
        fork
            send(0, 1'b1, 8'hA5, 1'b0, w);
            begin
                repeat (2) @(posedge CLK);
                #2 OUT_READY = 8'hFF;
            end
        join
        chk("bc2_wait", 64'(w), 64'(2));
        chk("bc2_data", OUT_DATA, {8{8'hA5}});
        idle(2);

        OUT_READY = 8'hFB;
        send(2, 1'b0, 8'h33, 1'b0, w);
        OUT_READY = 8'hFF;
        send(2, 1'b0, 8'h44, 1'b0, w);
        chk("refill_wait", 64'(w), 64'(0));
        chk("refill_valid", 64'(OUT_VALID[2]), 64'(1));
        chk("refill_data", 64'(OUT_DATA[16 +: 8]), 64'(8'h44));
        idle(2);

        for (int it = 0; it < 300; it++) begin
            OUT_READY = 8'($urandom);
            if ($urandom_range(3) == 0) idle(1);
            else send(int'($urandom_range(7)), $urandom_range(7) == 0,
                      8'($urandom), 1'b1, w);
        end
        OUT_READY = 8'hFF;
        idle(2);

        OUT_READY = 8'h00;
        send(1, 1'b0, 8'hC3, 1'b0, w);
        #1;
        OUT_READY = 8'hFF;
        nRST = 1'b0;
        for (int c = 0; c < N; c++) q[c].delete();
        #1;
        chk("midrst_valid", 64'(OUT_VALID), 64'(0));
        chk("midrst_data", OUT_DATA, 64'(0));
        chk("midrst_drop", 64'(DROP_CNT), 64'(0));
        @(negedge CLK);
        #2 nRST = 1'b1;
        idle(1);

        s6 = 3'd7; v6 = 1'b1; d6 = 8'h77;
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            chk("drop_ready", 64'(r6), 64'(1));
            @(posedge CLK);
            #1;
            chk("drop_valid", 64'(ov6), 64'(0));
            chk("drop_cnt", 64'(dc6), 64'(k < 3 ? k : 3));
        end
        s6 = 3'd5; d6 = 8'h99;
        @(negedge CLK);
        chk("n6_ready", 64'(r6), 64'(1));
        @(posedge CLK);
        #1;
        v6 = 1'b0;
        chk("n6_valid", 64'(ov6), 64'(6'b100000));
        chk("n6_data", 64'(od6[40 +: 8]), 64'(8'h99));
        chk("n6_drop_hold", 64'(dc6), 64'(3));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
Parametrised 1-to-N streaming demultiplexer. Successor to the combinational 1-to-8 demux.
- Routes a W-bit data word with valid/ready handshake to one of N output channels, or to all channels (broadcast).
- Each channel has a one-entry registered output slot.
- Sits between a single producer and N independent consumers; default N=8 matches the legacy 1-to-8 demux.

Parameters:
N, 8, number of output channels (2..64)
W, 8, data width in bits
CW, 8, width of the saturating drop counter

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
IN_DATA  input  W  input data word
IN_VALID  input  1  input word valid
IN_READY  output  1  block can accept the input word this cycle
SEL  input  SELW=max(1,$clog2(N))  destination channel index
BCAST  input  1  1 = deliver the word to all N channels
OUT_DATA  output  N*W  packed channel data; channel i occupies bits [i*W +: W]
OUT_VALID  output  N  per-channel valid
OUT_READY  input  N  per-channel consumer ready
DROP_CNT  output  CW  count of words dropped for out-of-range SEL

Behaviour:
- Reset: nRST low asynchronously clears OUT_VALID to 0, OUT_DATA to 0 and DROP_CNT to 0.
  - Reset is released synchronously to CLK.
  - A reset mid-transfer discards all held words; no partial delivery.
- Slot i state: OUT_VALID[i] = 1 means slot i is FULL; otherwise EMPTY.
- Slot i is "free" when !OUT_VALID[i] || OUT_READY[i]. A slot draining this cycle can be refilled in the same cycle.
- Input handshake: a word is accepted on a rising CLK edge when IN_VALID && IN_READY. No state changes when IN_VALID=0.
- IN_READY (combinational from OUT_VALID, OUT_READY, SEL, BCAST):
  - BCAST=1: IN_READY = all N slots free.
  - BCAST=0, SEL<N: IN_READY = slot[SEL] free.
  - BCAST=0, SEL>=N: IN_READY = 1 (drop path).
- Accept, unicast (SEL<N): OUT_DATA[SEL] <= IN_DATA and OUT_VALID[SEL] <= 1 on the next edge. Latency is 1 cycle, input edge to OUT_VALID.
- Accept, broadcast: every slot loads IN_DATA and sets valid on the same edge. SEL is ignored.
- Accept, SEL>=N and BCAST=0: the word is discarded and DROP_CNT increments by 1. DROP_CNT saturates at 2^CW-1 and does not wrap. This case only arises when N is not a power of two.
- Output handshake: slot i clears OUT_VALID[i] on an edge where OUT_VALID[i] && OUT_READY[i] and it is not being reloaded.
  - Reload in the same cycle wins: the slot stays FULL with the new data.
- OUT_DATA[i] holds its value while the slot is FULL. It is stable while OUT_VALID[i]=1 && !OUT_READY[i], and is not cleared on drain.
- Channels are independent: a stalled channel blocks only unicasts to that channel and all broadcasts.
- Ordering per channel is preserved; there is no reordering or buffering beyond one entry per channel.
- Full throughput: one word per cycle when the target consumer holds OUT_READY=1.
- Widths: SEL is compared against N with SEL zero-extended; N=2 gives SELW=1.

Decomposition:
- Package stream_demux_pkg:
  - function sel_width(n), returning max(1,$clog2(n));
  - localparam DEFAULT_N=8, DEFAULT_W=8.
- Sub-module demux_slot (parameter W): a one-entry register slot.
  - Inputs: CLK, nRST, load, load_data, out_ready.
  - Outputs: out_valid, out_data, free.
  - stream_demux instantiates N of these in a generate loop.
- Top level contains the ready/select/broadcast decode and the drop counter.

Test Plan:
1. Reset with OUT_READY=all 1s: assert nRST=0 mid-cycle -> OUT_VALID=0x00, DROP_CNT=0 immediately, without waiting for a CLK edge.
2. Unicast sweep, N=8, W=8, OUT_READY=0xFF: SEL=0..7 with IN_DATA=0xA0+SEL, one word per cycle.
   - After each edge, OUT_VALID equals 1<<SEL (the walking one, 0x01..0x80) and slot[SEL] holds 0xA0+SEL.
   - IN_READY stays 1 throughout.
3. Backpressure: OUT_READY[3]=0, send 0x11 then 0x22 to SEL=3.
   - First word is accepted.
   - IN_READY=0 for the second word until OUT_READY[3]=1, then 0x22 loads on that same edge.
   - SEL=5 traffic is accepted during the stall.
4. Broadcast: BCAST=1, IN_DATA=0x5A, OUT_READY=0xFE.
   - Accepted; OUT_VALID=0xFF and all slots hold 0x5A.
   - A second broadcast is held (IN_READY=0) until OUT_READY[0]=1.
5. Out-of-range drop, N=6, CW=2: send 5 words with SEL=7.
   - IN_READY=1 each cycle and OUT_VALID stays 0x00.
   - DROP_CNT goes 1, 2, 3, 3, 3 (saturation).
6. Same-cycle drain and refill: slot 2 FULL with 0x33, OUT_READY[2]=1, new word 0x44 to SEL=2.
   - Next cycle OUT_VALID[2]=1 with data 0x44; no bubble and no lost word.
